// File: rtl/spi_cfg_sequencer.sv
// ============================================================================
// Module      : spi_cfg_sequencer
// Description : Round-robin arbiter plus 16-bit SPI mode-0 write-frame
//               serializer that shares one configuration link among requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cfg_sequencer #(
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 done,
    output logic                 ncs,
    output logic                 sclk,
    output logic                 copi
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);

    state_t               state, state_nxt;
    logic [7:0]           div_cnt, div_cnt_nxt;
    logic [4:0]           bit_cnt, bit_cnt_nxt;
    logic [15:0]          shreg, shreg_nxt;
    logic [2:0]           ptr, ptr_nxt;
    logic [2:0]           offer_id, offer_id_nxt;
    logic [2:0]           grant_id_nxt;
    logic [NUM_REQ-1:0]   ready_nxt;
    logic                 busy_nxt, done_nxt, ncs_nxt, sclk_nxt, copi_nxt;

    logic [2:0]           win_hi, win_lo, winner;
    logic                 found_hi, found_lo, found;
    logic [6:0]           sel_addr;
    logic [7:0]           sel_data;
    logic                 div_last;

    assign div_last = (div_cnt == DIV_LAST);

    // Round-robin search: lowest requester at/above the pointer, else lowest below it.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (3'(i) >= ptr) begin
                    win_hi   = 3'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo   = 3'(i);
                    found_lo = 1'b1;
                end
            end
        end
        found  = found_hi | found_lo;
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (offer_id == 3'(i)) begin
                sel_addr = req_addr[7*i +: 7];
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ptr_nxt      = ptr;
        offer_id_nxt = offer_id;
        grant_id_nxt = grant_id;
        ready_nxt    = '0;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        ncs_nxt      = ncs;
        sclk_nxt     = sclk;
        copi_nxt     = copi;

        case (state)
            IDLE: begin
                if (req_ready != '0) begin
                    // Offer outstanding: this edge is the accept edge if the holder is still valid.
                    if ((req_ready & req_valid) != '0) begin
                        state_nxt    = SETUP;
                        div_cnt_nxt  = '0;
                        shreg_nxt    = {sel_addr, sel_data, 1'b0};
                        copi_nxt     = 1'b1;
                        ncs_nxt      = 1'b0;
                        busy_nxt     = 1'b1;
                        grant_id_nxt = offer_id;
                        ptr_nxt      = (offer_id == LAST_REQ) ? 3'd0 : offer_id + 3'd1;
                    end
                end else if (found) begin
                    offer_id_nxt = winner;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        ready_nxt[i] = (winner == 3'(i));
                    end
                end
            end

            SETUP: begin
                div_cnt_nxt = div_cnt + 8'd1;
                if (div_last) begin
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    sclk_nxt    = 1'b1;
                    state_nxt   = SHIFT;
                end
            end

            SHIFT: begin
                div_cnt_nxt = div_cnt + 8'd1;
                if (div_last) begin
                    div_cnt_nxt = '0;
                    if (bit_cnt == 5'd31) begin
                        state_nxt = HOLD;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                        if (bit_cnt[0]) begin
                            sclk_nxt = 1'b1;
                        end else begin
                            // Falling edge: present the next bit; zeros shift in after bit 0.
                            sclk_nxt  = 1'b0;
                            copi_nxt  = shreg[15];
                            shreg_nxt = {shreg[14:0], 1'b0};
                        end
                    end
                end
            end

            HOLD: begin
                div_cnt_nxt = div_cnt + 8'd1;
                if (div_last) begin
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    ncs_nxt     = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = GAP;
                end
            end

            GAP: begin
                div_cnt_nxt = div_cnt + 8'd1;
                if (div_last) begin
                    div_cnt_nxt = '0;
                    if (bit_cnt == 5'd1) begin
                        bit_cnt_nxt = '0;
                        busy_nxt    = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        bit_cnt_nxt = 5'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            offer_id  <= '0;
            grant_id  <= '0;
            req_ready <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ncs       <= 1'b1;
            sclk      <= 1'b0;
            copi      <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            ptr       <= ptr_nxt;
            offer_id  <= offer_id_nxt;
            grant_id  <= grant_id_nxt;
            req_ready <= ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            ncs       <= ncs_nxt;
            sclk      <= sclk_nxt;
            copi      <= copi_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
// Bench for spi_cfg_sequencer: waveform model derived from accept times,
// round-robin reference, on-wire frame decoder and directed literal checks.
`timescale 1ns/1ps
`default_nettype none

module tb_spi_cfg_sequencer;

    localparam int N     = 3;
    localparam int CD    = 4;
    localparam int FRAME = 36 * CD;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_addr  = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [2:0]     grant_id;
    logic           busy, done, ncs, sclk, copi;

    spi_cfg_sequencer #(.NUM_REQ(N), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .done(done),
        .ncs(ncs), .sclk(sclk), .copi(copi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_active = 1'b0;
    int          m_d      = 0;
    logic [15:0] m_frame  = '0;
    int          m_ptr    = 0;
    int          m_grant  = 0;
    bit          m_busy   = 1'b0;
    longint      cyc      = 0;
    longint      last_e0  = -1;
    logic [N-1:0] acc_vec = '0;
    bit          raise_en = 1'b0;
    int          idle_wait = 0;
    int          grant_log[$];
    longint      e0_log[$];

    // Wire-level decoder
    logic        prev_sclk = 1'b0, prev_ncs = 1'b1, copi_hi = 1'b0;
    logic [15:0] dec = '0;
    int          rises = 0, low_cnt = 0, done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_frame = '0;
    int          last_rises = 0, last_low = 0, frames_done = 0;

    task automatic check(input string name, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int j = 0; j < N; j++) begin
            if (v[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    task automatic raise(input int i, input logic [6:0] a, input logic [7:0] d);
        req_valid[i]      = 1'b1;
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
        acc_vec = req_ready & req_valid;
    endtask

    task automatic step();
        int w, f, pick;
        logic e_ncs, e_sclk, e_copi, e_done;
        logic [15:0] expf;
        bit allow;
        @(negedge clk);
        cyc++;
        if (m_active) m_d++;

        if (acc_vec != '0) begin
            w = rr_pick(req_valid, m_ptr);
            check("accept_onehot", acc_vec, (w < 0) ? 0 : (longint'(1) << w));
            if (last_e0 >= 0) check("accept_spacing", (cyc - last_e0) >= FRAME, 1);
            if (w >= 0) begin
                m_frame  = {1'b1, req_addr[7*w +: 7], req_data[8*w +: 8]};
                m_active = 1'b1;
                m_d      = 0;
                m_grant  = w;
                m_ptr    = (w + 1) % N;
                grant_log.push_back(w);
                e0_log.push_back(cyc);
                exp_q.push_back(m_frame);
                req_valid[w] = 1'b0;
                last_e0  = cyc;
                done_cnt = 0;
            end
        end

        // Expected pins from the elapsed time since the accept edge
        if (m_active) begin
            e_ncs  = (m_d >= 34*CD);
            e_sclk = (m_d >= CD) && (m_d < 33*CD) && ((((m_d - CD) / CD) % 2) == 0);
            f      = m_d / (2*CD);
            e_copi = (f >= 16) ? 1'b0 : m_frame[15 - f];
            m_busy = (m_d < FRAME);
            e_done = (m_d == 34*CD);
        end else begin
            e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0; m_busy = 1'b0; e_done = 1'b0;
        end
        check("ncs", ncs, e_ncs);
        check("sclk", sclk, e_sclk);
        check("copi", copi, e_copi);
        check("busy", busy, m_busy);
        check("done", done, e_done);
        check("grant_id", grant_id, m_grant);
        if (m_busy) begin
            check("ready_while_busy", req_ready, 0);
        end else if (req_valid == '0) begin
            check("ready_no_request", req_ready, 0);
        end else begin
            pick = rr_pick(req_valid, m_ptr);
            check("ready_offer", (req_ready == '0) || (longint'(req_ready) == (longint'(1) << pick)), 1);
        end
        if (!m_busy && req_valid != '0) begin
            idle_wait++;
            check("grant_latency", idle_wait <= 3, 1);
        end else begin
            idle_wait = 0;
        end

        // Decode the wire independently of the model
        if (!ncs) low_cnt++;
        if (done) done_cnt++;
        if (sclk && !prev_sclk) begin
            dec = {dec[14:0], copi};
            rises++;
            copi_hi = copi;
        end else if (sclk) begin
            check("copi_stable_high", copi, copi_hi);
        end
        if (ncs && !prev_ncs) begin
            last_frame = dec; last_rises = rises; last_low = low_cnt;
            frames_done++;
            if (exp_q.size() == 0) begin
                check("frame_unexpected", 1, 0);
            end else begin
                expf = exp_q.pop_front();
                check("frame_value", dec, expf);
            end
            check("frame_rises", rises, 16);
            check("ncs_low_cycles", low_cnt, 34*CD);
            dec = '0; rises = 0; low_cnt = 0;
        end
        prev_sclk = sclk;
        prev_ncs  = ncs;

        if (raise_en) begin
            // Requests only appear while a frame runs or when nothing is pending
            allow = (req_valid == '0) || (m_active && m_d < 30*CD);
            for (int i = 0; i < N; i++) begin
                if (allow && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i]       = 1'b1;
                    req_addr[7*i +: 7] = 7'($urandom);
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        acc_vec = req_ready & req_valid;
    endtask

    task automatic run_until_frames(input int target, input int budget);
        int k;
        k = 0;
        while (frames_done < target && k < budget) begin
            step();
            k++;
        end
        check("frame_timeout", frames_done >= target, 1);
    endtask

    task automatic reset_mid();
        #2;
        check("pre_rst_sclk_high", sclk, 1);
        rst = 1'b1;
        #1;
        check("rst_ncs_immediate", ncs, 1);
        check("rst_sclk_immediate", sclk, 0);
        check("rst_busy_immediate", busy, 0);
        m_active = 1'b0; m_d = 0; m_ptr = 0; m_grant = 0; m_busy = 1'b0;
        last_e0 = -1; req_valid = '0; acc_vec = '0; idle_wait = 0;
        exp_q.delete(); grant_log.delete(); e0_log.delete();
        dec = '0; rises = 0; low_cnt = 0; prev_sclk = 1'b0; prev_ncs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, fb;
        repeat (3) @(negedge clk);
        check("reset_ncs", ncs, 1);
        check("reset_sclk", sclk, 0);
        check("reset_copi", copi, 0);
        check("reset_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_grant", grant_id, 0);
        rst = 1'b0;

        // Single request, with a second one arriving mid-frame
        raise(0, 7'h04, 8'h80);
        repeat (30) step();
        raise(1, 7'h02, 8'hFF);
        run_until_frames(1, 400);
        check("t1_frame_8480", last_frame, 16'h8480);
        check("t1_ncs_low_136", last_low, 136);
        check("t1_rises_16", last_rises, 16);
        check("t1_one_done", done_cnt, 1);
        run_until_frames(2, 400);
        check("t2_frame_82ff", last_frame, 16'h82FF);
        check("t2_second_grant", (grant_log.size() >= 2) ? grant_log[1] : -1, 1);
        check("t2_spacing_144", (e0_log.size() >= 2) ? (e0_log[1] - e0_log[0] >= 144) : 0, 1);

        // Undecoded address goes out unchanged; abort mid-shift
        raise(2, 7'h7F, 8'h5A);
        k = 0;
        while (!(e0_log.size() == 3 && m_d == 15*CD + 1) && k < 1000) begin
            step();
            k++;
        end
        check("t5_reached_bit7", (e0_log.size() == 3 && m_d == 15*CD + 1), 1);
        reset_mid();
        fb = frames_done;
        raise(2, 7'h7F, 8'h5A);
        run_until_frames(fb + 1, 400);
        check("t5_full_frame_after_rst", last_frame, 16'hFF5A);

        // Simultaneous requests from pointer 0, then both re-asserted
        reset_mid_free: begin end
        rst = 1'b1;
        @(negedge clk);
        m_ptr = 0; m_grant = 0; m_active = 1'b0; last_e0 = -1; grant_log.delete(); e0_log.delete();
        acc_vec = '0; prev_ncs = 1'b1; prev_sclk = 1'b0;
        rst = 1'b0;
        fb = frames_done;
        raise(0, 7'h00, 8'hFF);
        raise(1, 7'h04, 8'h80);
        run_until_frames(fb + 1, 400);
        raise(0, 7'h02, 8'hFF);
        run_until_frames(fb + 2, 400);
        raise(1, 7'h04, 8'h40);
        run_until_frames(fb + 3, 400);
        run_until_frames(fb + 4, 400);
        check("t3_order_len", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("t3_order_0", grant_log[0], 0);
            check("t3_order_1", grant_log[1], 1);
            check("t3_order_2", grant_log[2], 0);
            check("t3_order_3", grant_log[3], 1);
        end

        // Randomized traffic
        raise_en = 1'b1;
        repeat (4000) step();
        raise_en = 1'b0;
        k = 0;
        while (!(req_valid == '0 && !m_busy) && k < 3000) begin
            step();
            k++;
        end
        check("drain_complete", (req_valid == '0 && !m_busy), 1);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
